mod_exp_ctrl_rad2: RTL

- Sequencer that computes result = base^exp mod m using left-to-right square-and-multiply.
- Acts as the initiator for a modular-multiplier datapath: it issues a one-cycle enable pulse with registered operands, then waits for the multiplier's one-cycle done pulse.
- Sits above the interleaved modular multiplier in the public-key datapath. Owns no arithmetic besides a compare-to-one.

---
 rtl/mod_exp_ctrl_rad2_if.sv | 44 ++++
 rtl/mod_exp_ctrl_rad2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl_rad2_if.sv
// ---------------------------------------------------------------------------
// mod_exp_ctrl_rad2_if
//
// Handshake bundle between the square-and-multiply sequencer (master) and
// the interleaved modular multiplier (slave).
//
// Signals:
//   mul_enable_p    master->slave  one-cycle start pulse for a multiplication
//   mul_a           master->slave  operand a, stable from enable until done
//   mul_b           master->slave  operand b, stable from enable until done
//   mul_m           master->slave  modulus, stable for the whole exponentiation
//   mul_y           slave->master  product, valid only while mul_done_irq_p is high
//   mul_done_irq_p  slave->master  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface mod_exp_ctrl_rad2_if #(
    parameter int NBITS = 4096
) ();

    logic             mul_enable_p;
    logic [NBITS-1:0] mul_a;
    logic [NBITS-1:0] mul_b;
    logic [NBITS-1:0] mul_m;
    logic [NBITS-1:0] mul_y;
    logic             mul_done_irq_p;

    modport master (
        output mul_enable_p,
        output mul_a,
        output mul_b,
        output mul_m,
        input  mul_y,
        input  mul_done_irq_p
    );

    modport slave (
        input  mul_enable_p,
        input  mul_a,
        input  mul_b,
        input  mul_m,
        output mul_y,
        output mul_done_irq_p
    );

endinterface

// File: rtl/mod_exp_ctrl_rad2.sv
// ---------------------------------------------------------------------------
// mod_exp_ctrl_rad2
//
// Left-to-right square-and-multiply sequencer computing
// result = base^exp mod m. It performs no arithmetic itself apart from a
// compare-to-one on the modulus; every product is delegated to an external
// modular multiplier over the mul interface.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start_p      one-cycle start pulse, only honoured while idle
//   base         base operand (must be < m), sampled with start_p
//   exp          exponent, sampled with start_p
//   m            modulus (must be >= 1), sampled with start_p
//   result       final value, held from done until the next completed run
//   done_irq_p   one-cycle pulse while result becomes valid
//   busy         high from the cycle after start_p through the done cycle
//   mul          master side of the multiplier handshake
// ---------------------------------------------------------------------------
module mod_exp_ctrl_rad2 #(
    parameter int NBITS = 4096,
    parameter int EBITS = 4096,
    parameter int CBITS = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_p,
    input  logic [NBITS-1:0]    base,
    input  logic [EBITS-1:0]    exp,
    input  logic [NBITS-1:0]    m,
    output logic [NBITS-1:0]    result,
    output logic                done_irq_p,
    output logic                busy,
    mod_exp_ctrl_rad2_if.master mul
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SCAN      = 3'd1;
    localparam logic [2:0] SQ_ISSUE  = 3'd2;
    localparam logic [2:0] SQ_WAIT   = 3'd3;
    localparam logic [2:0] MUL_ISSUE = 3'd4;
    localparam logic [2:0] MUL_WAIT  = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    localparam logic [CBITS-1:0] CNT_INIT = CBITS'(EBITS);
    localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
    localparam logic [NBITS-1:0] NB_ONE   = NBITS'(1);

    // Registered state
    logic [2:0]       state;
    logic [EBITS-1:0] e_sh;
    logic [CBITS-1:0] cnt;
    logic [NBITS-1:0] r;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] m_q;
    logic             one_q;
    logic [NBITS-1:0] mul_a_q;
    logic [NBITS-1:0] mul_b_q;
    logic             mul_en_q;

    // Next-state values
    logic [2:0]       state_nxt;
    logic [EBITS-1:0] e_sh_nxt;
    logic [CBITS-1:0] cnt_nxt;
    logic [NBITS-1:0] r_nxt;
    logic [NBITS-1:0] b_q_nxt;
    logic [NBITS-1:0] m_q_nxt;
    logic             one_nxt;
    logic [NBITS-1:0] mul_a_nxt;
    logic [NBITS-1:0] mul_b_nxt;
    logic             mul_en_nxt;
    logic [NBITS-1:0] result_nxt;
    logic             done_nxt;

    // Helpers
    logic             cur_bit;
    logic             last_bit;
    logic [EBITS-1:0] e_shl;
    logic [CBITS-1:0] cnt_dec;
    logic [NBITS-1:0] one_val;

    assign cur_bit  = e_sh[EBITS-1];
    assign last_bit = (cnt == CNT_ONE);
    assign e_shl    = e_sh << 1;
    assign cnt_dec  = cnt - CNT_ONE;
    // The multiplicative identity reduced mod m: 1, or 0 when m == 1.
    assign one_val  = {{(NBITS-1){1'b0}}, one_q};

    assign busy             = (state != IDLE);
    assign mul.mul_enable_p = mul_en_q;
    assign mul.mul_a        = mul_a_q;
    assign mul.mul_b        = mul_b_q;
    assign mul.mul_m        = m_q;

    // Next-state logic. Operands and the enable pulse are loaded on the edge
    // that enters an ISSUE state, so the pulse and its operands are visible
    // in exactly the ISSUE cycle and the operands then hold through the WAIT
    // state. result and done_irq_p are likewise loaded on the edge entering
    // DONE so the pulse coincides with the valid result.
    always_comb begin
        state_nxt  = state;
        e_sh_nxt   = e_sh;
        cnt_nxt    = cnt;
        r_nxt      = r;
        b_q_nxt    = b_q;
        m_q_nxt    = m_q;
        one_nxt    = one_q;
        mul_a_nxt  = mul_a_q;
        mul_b_nxt  = mul_b_q;
        mul_en_nxt = 1'b0;
        result_nxt = result;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start_p) begin
                    b_q_nxt   = base;
                    m_q_nxt   = m;
                    one_nxt   = (m != NB_ONE);
                    e_sh_nxt  = exp;
                    cnt_nxt   = CNT_INIT;
                    r_nxt     = {{(NBITS-1){1'b0}}, (m != NB_ONE)};
                    state_nxt = SCAN;
                end
            end

            // Skip leading zeros one bit per cycle; the first 1 seeds the
            // accumulator with the base without any multiplication.
            SCAN: begin
                e_sh_nxt = e_shl;
                cnt_nxt  = cnt_dec;
                if (cur_bit) begin
                    r_nxt = b_q;
                    if (last_bit) begin
                        result_nxt = b_q;
                        done_nxt   = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        mul_a_nxt  = b_q;
                        mul_b_nxt  = b_q;
                        mul_en_nxt = 1'b1;
                        state_nxt  = SQ_ISSUE;
                    end
                end else if (last_bit) begin
                    r_nxt      = one_val;
                    result_nxt = one_val;
                    done_nxt   = 1'b1;
                    state_nxt  = DONE;
                end
            end

            SQ_ISSUE: begin
                state_nxt = SQ_WAIT;
            end

            // After squaring, a set bit still needs its multiply before the
            // bit is consumed; a clear bit is consumed right away.
            SQ_WAIT: begin
                if (mul.mul_done_irq_p) begin
                    r_nxt = mul.mul_y;
                    if (cur_bit) begin
                        mul_a_nxt  = mul.mul_y;
                        mul_b_nxt  = b_q;
                        mul_en_nxt = 1'b1;
                        state_nxt  = MUL_ISSUE;
                    end else begin
                        e_sh_nxt = e_shl;
                        cnt_nxt  = cnt_dec;
                        if (last_bit) begin
                            result_nxt = mul.mul_y;
                            done_nxt   = 1'b1;
                            state_nxt  = DONE;
                        end else begin
                            mul_a_nxt  = mul.mul_y;
                            mul_b_nxt  = mul.mul_y;
                            mul_en_nxt = 1'b1;
                            state_nxt  = SQ_ISSUE;
                        end
                    end
                end
            end

            MUL_ISSUE: begin
                state_nxt = MUL_WAIT;
            end

            MUL_WAIT: begin
                if (mul.mul_done_irq_p) begin
                    r_nxt    = mul.mul_y;
                    e_sh_nxt = e_shl;
                    cnt_nxt  = cnt_dec;
                    if (last_bit) begin
                        result_nxt = mul.mul_y;
                        done_nxt   = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        mul_a_nxt  = mul.mul_y;
                        mul_b_nxt  = mul.mul_y;
                        mul_en_nxt = 1'b1;
                        state_nxt  = SQ_ISSUE;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State registers. Reset returns everything to zero/IDLE immediately,
    // so a multiplier completion still in flight lands in IDLE and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            e_sh       <= '0;
            cnt        <= '0;
            r          <= '0;
            b_q        <= '0;
            m_q        <= '0;
            one_q      <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_en_q   <= 1'b0;
            result     <= '0;
            done_irq_p <= 1'b0;
        end else begin
            state      <= state_nxt;
            e_sh       <= e_sh_nxt;
            cnt        <= cnt_nxt;
            r          <= r_nxt;
            b_q        <= b_q_nxt;
            m_q        <= m_q_nxt;
            one_q      <= one_nxt;
            mul_a_q    <= mul_a_nxt;
            mul_b_q    <= mul_b_nxt;
            mul_en_q   <= mul_en_nxt;
            result     <= result_nxt;
            done_irq_p <= done_nxt;
        end
    end

endmodule
